// File: rtl/dmem_bram_if.sv
// Request/response bus between the LSU (master) and the data memory (slave).
// Valid/ready request channel plus a fixed-latency, non-backpressured response.
interface dmem_bram_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_fault;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_bram.sv
// RV32 data memory: four byte-lane banks, funct3 decode with load extension,
// row-crossing accesses split over two cycles or faulted, zero sweep after reset.
module dmem_bram #(
    parameter int ADDR_WIDTH     = 11,
    parameter int MISALIGN_MODE  = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_bram_if.slave  bus,
    output logic        busy
);
    localparam int RW   = ADDR_WIDTH - 2;
    localparam int ROWS = 1 << RW;

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SPLIT} state_t;

    state_t state_q, state_d;

    logic [RW-1:0] clr_row_q;
    logic [7:0]    mem [4][ROWS];

    logic [1:0]    h_off;
    logic [2:0]    h_n;
    logic [RW-1:0] h_row;
    logic [31:0]   h_wdata;
    logic          h_write;
    logic [2:0]    h_f3;
    logic [31:0]   h_lo;

    logic [2:0] n_req;
    logic [2:0] last_byte;
    logic       crossing;
    logic       illegal;
    logic       fault_req;
    logic       accept;

    logic          phase;
    logic [1:0]    a_off;
    logic [2:0]    a_n;
    logic [31:0]   a_wdata;
    logic [RW-1:0] a_row;
    logic [2:0]    pos [4];
    logic [2:0]    kk [4];
    logic [3:0]    lane_en;
    logic [7:0]    lane_wd [4];
    logic [31:0]   rbytes;
    logic          we_go;

    function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b[7:0]};
            3'b100:  extend = {24'h0, b[7:0]};
            3'b001:  extend = {{16{b[15]}}, b[15:0]};
            3'b101:  extend = {16'h0, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   n_req = 3'd1;
            2'b01:   n_req = 3'd2;
            default: n_req = 3'd4;
        endcase
        last_byte = {1'b0, bus.req_addr[1:0]} + n_req - 3'd1;
        crossing  = last_byte > 3'd3;
        illegal   = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110)
                    || (bus.req_write && bus.req_funct3[2]);
        fault_req = illegal || (crossing && (MISALIGN_MODE != 0));
        accept    = bus.req_valid && bus.req_ready;
    end

    // One lane-mapping path serves both rows: in SPLIT the held request is
    // replayed against row+1, with lane positions shifted up by four bytes.
    always_comb begin
        phase   = (state_q == ST_SPLIT);
        a_off   = phase ? h_off   : bus.req_addr[1:0];
        a_n     = phase ? h_n     : n_req;
        a_wdata = phase ? h_wdata : bus.req_wdata;
        a_row   = phase ? h_row + RW'(1) : bus.req_addr[ADDR_WIDTH-1:2];
        lane_en = '0;
        rbytes  = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            pos[l]     = 3'(l) + (phase ? 3'd4 : 3'd0);
            kk[l]      = pos[l] - {1'b0, a_off};
            lane_wd[l] = a_wdata[{kk[l][1:0], 3'b000} +: 8];
            if ((pos[l] >= {1'b0, a_off}) && (kk[l] < a_n)) begin
                lane_en[l] = 1'b1;
                rbytes[{kk[l][1:0], 3'b000} +: 8] = mem[l][a_row];
            end
        end
        we_go = ((state_q == ST_IDLE) && accept && !fault_req && bus.req_write)
                || ((state_q == ST_SPLIT) && h_write);
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < 4; l++) begin
            if (state_q == ST_CLEAR) begin
                mem[l][clr_row_q] <= '0;
            end else if (we_go && lane_en[l]) begin
                mem[l][a_row] <= lane_wd[l];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (&clr_row_q) state_d = ST_IDLE;
            ST_IDLE:  if (accept && !fault_req && crossing) state_d = ST_SPLIT;
            ST_SPLIT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_row_q     <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_fault <= 1'b0;
            busy          <= (CLEAR_ON_RESET != 0);
            h_off         <= '0;
            h_n           <= '0;
            h_row         <= '0;
            h_wdata       <= '0;
            h_write       <= 1'b0;
            h_f3          <= '0;
            h_lo          <= '0;
        end else begin
            state_q       <= state_d;
            bus.req_ready <= (state_d == ST_IDLE);
            busy          <= (state_d == ST_CLEAR);
            bus.rsp_valid <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= '0;
            if (state_q == ST_CLEAR) clr_row_q <= clr_row_q + RW'(1);
            if ((state_q == ST_IDLE) && accept) begin
                if (fault_req) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_fault <= 1'b1;
                end else if (crossing) begin
                    h_off   <= bus.req_addr[1:0];
                    h_n     <= n_req;
                    h_row   <= bus.req_addr[ADDR_WIDTH-1:2];
                    h_wdata <= bus.req_wdata;
                    h_write <= bus.req_write;
                    h_f3    <= bus.req_funct3;
                    h_lo    <= rbytes;
                end else begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= bus.req_write ? 32'h0 : extend(rbytes, bus.req_funct3);
                end
            end
            if (state_q == ST_SPLIT) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= h_write ? 32'h0 : extend(h_lo | rbytes, h_f3);
            end
        end
    end
endmodule

// File: tb/tb_dmem_bram.sv
// Directed bench for dmem_bram: split instance (dut0) and fault instance (dut1)
// share clock and reset; expected values are hand-computed constants.
module tb_dmem_bram;
    logic clk = 1'b0;
    logic reset_n;
    logic busy0, busy1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_bram_if #(.ADDR_WIDTH(11)) bus0 ();
    dmem_bram_if #(.ADDR_WIDTH(11)) bus1 ();

    dmem_bram #(.ADDR_WIDTH(11), .MISALIGN_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .busy(busy0));
    dmem_bram #(.ADDR_WIDTH(11), .MISALIGN_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .busy(busy1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit inst, input logic v, input logic wr,
                         input logic [2:0] f3, input logic [10:0] a, input logic [31:0] wd);
        if (inst) begin
            bus1.req_valid = v; bus1.req_write = wr; bus1.req_funct3 = f3;
            bus1.req_addr = a; bus1.req_wdata = wd;
        end else begin
            bus0.req_valid = v; bus0.req_write = wr; bus0.req_funct3 = f3;
            bus0.req_addr = a; bus0.req_wdata = wd;
        end
    endtask

    task automatic do_req(input bit inst, input logic wr, input logic [2:0] f3,
                          input logic [10:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat,
                          output logic rdy_after);
        int n;
        logic rv;
        @(negedge clk);
        n = 0;
        while (!(inst ? bus1.req_ready : bus0.req_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("ready_wait", 32'd0, 32'd1);
        drive(inst, 1'b1, wr, f3, a, wd);
        @(posedge clk); #1;
        rdy_after = inst ? bus1.req_ready : bus0.req_ready;
        drive(inst, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
        lat = 1;
        rv = inst ? bus1.rsp_valid : bus0.rsp_valid;
        while (!rv && lat < 4) begin
            @(posedge clk); #1;
            lat++;
            rv = inst ? bus1.rsp_valid : bus0.rsp_valid;
        end
        if (!rv) lat = 99;
        rd  = inst ? bus1.rsp_rdata : bus0.rsp_rdata;
        flt = inst ? bus1.rsp_fault : bus0.rsp_fault;
    endtask

    // Counts edges after reset release until busy0 drops; flags any response pulse.
    task automatic measure_clear(output int cnt, output logic rdy, output logic saw_rsp);
        cnt = 0;
        saw_rsp = 1'b0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (bus0.rsp_valid) saw_rsp = 1'b1;
        end while (busy0 && cnt < 2000);
        rdy = bus0.req_ready;
    endtask

    task automatic load_chk(input bit inst, input string tag, input logic [2:0] f3,
                            input logic [10:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic flt, ra;
        int lat;
        do_req(inst, 1'b0, f3, a, 32'd0, rd, flt, lat, ra);
        check(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic flt, ra, rdy, saw;
        int lat, cnt;

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus0.req_ready), 32'd0);
        check("rst_busy", 32'(busy0), 32'd1);
        check("rst_rdata", bus0.rsp_rdata, 32'd0);
        reset_n = 1'b1;
        measure_clear(cnt, rdy, saw);
        check("clear_len_first", 32'(cnt), 32'd512);

        // preload row 5, then reset and confirm the sweep zeroes it
        do_req(1'b0, 1'b1, 3'b010, 11'h014, 32'hDEADBEEF, rd, flt, lat, ra);
        check("preload_sw_lat", 32'(lat), 32'd1);
        load_chk(1'b0, "preload_lw", 3'b010, 11'h014, 32'hDEADBEEF);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        measure_clear(cnt, rdy, saw);
        check("clear_len", 32'(cnt), 32'd512);
        check("clear_ready_rise", 32'(rdy), 32'd1);
        load_chk(1'b0, "clear_lw_row5", 3'b010, 11'h014, 32'h0);

        // back-to-back store then load to the same word
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'b010, 11'h010, 32'h12345678);
        @(posedge clk); #1;
        check("b2b_sw_valid", 32'(bus0.rsp_valid), 32'd1);
        check("b2b_sw_rdata", bus0.rsp_rdata, 32'd0);
        check("b2b_ready", 32'(bus0.req_ready), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 11'h010, 32'd0);
        @(posedge clk); #1;
        check("b2b_lw_valid", 32'(bus0.rsp_valid), 32'd1);
        check("b2b_lw_rdata", bus0.rsp_rdata, 32'h12345678);
        check("b2b_lw_fault", 32'(bus0.rsp_fault), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);

        // byte store and extension
        do_req(1'b0, 1'b1, 3'b000, 11'h021, 32'h00000080, rd, flt, lat, ra);
        check("sb_lat", 32'(lat), 32'd1);
        load_chk(1'b0, "lb_sext", 3'b000, 11'h021, 32'hFFFFFF80);
        load_chk(1'b0, "lbu_zext", 3'b100, 11'h021, 32'h00000080);
        load_chk(1'b0, "lw_after_sb", 3'b010, 11'h020, 32'h00008000);
        do_req(1'b0, 1'b1, 3'b001, 11'h042, 32'h0000A55A, rd, flt, lat, ra);
        load_chk(1'b0, "lh_sext", 3'b001, 11'h042, 32'hFFFFA55A);
        load_chk(1'b0, "lhu_zext", 3'b101, 11'h042, 32'h0000A55A);

        // split row-crossing store
        do_req(1'b0, 1'b1, 3'b010, 11'h003, 32'hAABBCCDD, rd, flt, lat, ra);
        check("split_ready_low", 32'(ra), 32'd0);
        check("split_sw_lat", 32'(lat), 32'd2);
        check("split_sw_rdata", rd, 32'd0);
        do_req(1'b0, 1'b0, 3'b010, 11'h003, 32'd0, rd, flt, lat, ra);
        check("split_lw_lat", 32'(lat), 32'd2);
        check("split_lw", rd, 32'hAABBCCDD);
        load_chk(1'b0, "split_row0", 3'b010, 11'h000, 32'hDD000000);
        load_chk(1'b0, "split_row1", 3'b010, 11'h004, 32'h00AABBCC);

        // fault instance: misaligned half rejected, memory untouched
        do_req(1'b1, 1'b1, 3'b001, 11'h003, 32'h0000BEEF, rd, flt, lat, ra);
        check("mis_fault", 32'(flt), 32'd1);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_rdata", rd, 32'd0);
        load_chk(1'b1, "mis_row0", 3'b010, 11'h000, 32'h0);
        load_chk(1'b1, "mis_row1", 3'b010, 11'h004, 32'h0);

        // illegal funct3 in split mode
        do_req(1'b0, 1'b0, 3'b011, 11'h030, 32'd0, rd, flt, lat, ra);
        check("f3_3_fault", 32'(flt), 32'd1);
        do_req(1'b0, 1'b1, 3'b100, 11'h030, 32'h000000FF, rd, flt, lat, ra);
        check("sbu_fault", 32'(flt), 32'd1);
        check("sbu_lat", 32'(lat), 32'd1);
        do_req(1'b0, 1'b0, 3'b110, 11'h030, 32'd0, rd, flt, lat, ra);
        check("lwu_fault", 32'(flt), 32'd1);
        load_chk(1'b0, "sbu_no_write", 3'b010, 11'h030, 32'h0);

        // top-row wrap
        do_req(1'b0, 1'b1, 3'b001, 11'h7FF, 32'h0000BEEF, rd, flt, lat, ra);
        check("wrap_lat", 32'(lat), 32'd2);
        load_chk(1'b0, "wrap_top", 3'b100, 11'h7FF, 32'h000000EF);
        load_chk(1'b0, "wrap_bottom", 3'b100, 11'h000, 32'h000000BE);

        // reset while in SPLIT
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'b010, 11'h0FE, 32'h11223344);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 32'd0);
        check("midsplit_no_rsp_a", 32'(bus0.rsp_valid), 32'd0);
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        check("midsplit_no_rsp_b", 32'(bus0.rsp_valid), 32'd0);
        check("midsplit_busy", 32'(busy0), 32'd1);
        @(negedge clk); reset_n = 1'b1;
        measure_clear(cnt, rdy, saw);
        check("midsplit_clear_len", 32'(cnt), 32'd512);
        check("midsplit_no_rsp_sweep", 32'(saw), 32'd0);
        load_chk(1'b0, "midsplit_row63", 3'b010, 11'h0FC, 32'h0);
        load_chk(1'b0, "midsplit_row64", 3'b010, 11'h100, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/dmem_bram.md
Name: dmem_bram

Overview:
- Parametrised RV32 data memory: four byte-lane BRAM banks behind a valid/ready request port and a fixed-latency response port.
- Decodes RISC-V load/store funct3: byte/half/word size, sign or zero extension.
- Splits row-crossing misaligned accesses into two cycles, or faults them, selected by parameter.
- Zero-fills the array after reset with a sweep sequencer. Sits between the core's LSU and the bus.

Parameters:
- ADDR_WIDTH, 11, byte address width; ROWS = 2^(ADDR_WIDTH-2) 32-bit rows.
- MISALIGN_MODE, 0, 0 = split row-crossing accesses into two row cycles; 1 = reject with fault.
- CLEAR_ON_RESET, 1, 1 = zero every row after reset release; 0 = contents undefined, start in IDLE.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: size in [1:0] (00 B, 01 H, 10 W); [2] = unsigned load.
- req_addr  in  ADDR_WIDTH  byte address, little-endian.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  single-cycle response pulse, no backpressure.
- rsp_rdata  out  32  load result, extended; 0 for stores and faults.
- rsp_fault  out  1  qualifies rsp_valid: illegal funct3 or misaligned in MISALIGN_MODE=1.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async assert): state <= CLEAR if CLEAR_ON_RESET, else IDLE.
  - Also: row counter 0, rsp_valid 0, rsp_rdata 0, rsp_fault 0, req_ready 0.
  - busy = CLEAR_ON_RESET.
- The array is never reset directly; only the CLEAR sweep zeroes it.
- CLEAR state:
  - Writes 0 to all four lanes of row[counter], one row per cycle.
  - req_ready 0, busy 1; after row ROWS-1, go to IDLE.
  - Sweep length is exactly ROWS cycles.
- IDLE state:
  - req_ready 1, busy 0. A request is accepted on a cycle with req_valid & req_ready.
  - Span: bytes = 1/2/4 from funct3[1:0]; crossing = (addr[1:0] + bytes - 1) > 3.
  - Illegal request: funct3 in {3, 7}; a store with funct3[2]=1; or funct3 = 6 (LWU is not RV32).
  - Illegal request: no write; next cycle rsp_valid=1, rsp_fault=1, rsp_rdata=0.
  - Legal, not crossing: bank writes commit at the accept edge; the response is issued the next cycle (latency 1).
  - Legal, crossing, MISALIGN_MODE=1: treated as illegal (fault, no write).
  - Legal, crossing, MISALIGN_MODE=0:
    - Accept edge: lanes in row addr[ADDR_WIDTH-1:2] are committed or read.
    - Go to SPLIT; req_ready 0 for that cycle.
- SPLIT state:
  - Remaining bytes are accessed in the next row (row index + 1, modulo ROWS).
  - Next cycle: rsp_valid with merged data (latency 2); return to IDLE.
- Byte ordering: byte k of the access goes to byte address addr+k (mod 2^ADDR_WIDTH).
  - Write lane k = req_wdata[8k+7:8k].
  - Unused lanes are untouched on writes and not driven into rsp_rdata.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is unchanged.
- Throughput: back-to-back non-crossing requests are accepted every cycle; one response per cycle.
- Hazard: a load the cycle after a store to overlapping bytes returns the new data.
- Stores: produce rsp_valid with rsp_rdata=0, rsp_fault=0.
- Address wrap: an access crossing the top row wraps to row 0; e.g. SH at 2^ADDR_WIDTH-1 writes the top byte and byte 0.
- Reset mid-SPLIT: the first half may already be committed; no response is issued; restart per reset rules.
- req_* is ignored while req_ready=0; the outputs are don't-care except rsp_valid.

Test Plan:
- Clear sweep: preload row 5 = 0xDEADBEEF, pulse reset_n low, release -> busy high exactly 512 cycles, req_ready rises with busy falling, LW 0x014 returns 0x00000000.
- Aligned word: SW 0x12345678 @0x010 then LW @0x010 on the next cycle -> rsp_valid each cycle, second rsp_rdata 0x12345678, rsp_fault 0.
- Byte extension: SB 0x80 @0x021 -> LB @0x021 = 0xFFFFFF80, LBU = 0x00000080, LW @0x020 = 0x00008000 after clear.
- Split (MISALIGN_MODE=0): SW 0xAABBCCDD @0x003 -> req_ready low one cycle, rsp 2 cycles after accept; LW @0x003 = 0xAABBCCDD; LW @0x000 = 0xDD000000; LW @0x004 = 0x00AABBCC.
- Fault (MISALIGN_MODE=1): SH @0x003 -> rsp_fault 1 at latency 1, memory unchanged. Any mode: funct3=3 or SBU (store, funct3=4) -> fault, no write.
- Wrap: SH 0xBEEF @0x7FF -> LBU @0x7FF = 0xEF, LBU @0x000 = 0xBE.
- Mid-SPLIT reset: assert reset_n low during SPLIT -> rsp_valid never pulses, clear sweep restarts from row 0.
